diffusion_err_store: RTL and testbench
======================================

Name: diffusion_err_store

Overview:
- Parametrised successor to the chroma dither error-diffusion store stage.
- Splits each channel's 3 diffusion errors into left/top carries and holds the left carries in registers for the next macroblock.
- Writes the top carries to an external row RAM indexed by MB column. Also reads them back for the macroblock below and clears the row buffer at frame start.
- Sits between the dither/quantiser stage and the next-MB prediction setup.

Parameters:
NUM_CH, 2, number of channels (U,V)
ERR_W, 8, signed width of one error value
ADDR_W, 10, row RAM address width (max 2^ADDR_W MB columns)

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  one-cycle command strobe, accepted only when busy=0
op  in  2  command: 0 STORE, 1 LOAD, 2 CLR_LEFT, 3 CLR_TOP; sampled with start
x  in  ADDR_W  MB column for STORE/LOAD; sampled with start
mb_w  in  ADDR_W  row length for CLR_TOP; sampled with start
derr  in  NUM_CH*3*ERR_W  channel c error k at [(c*3+k)*ERR_W +: ERR_W], signed; sampled with start
left_derr  out  NUM_CH*2*ERR_W  left carries, lane (c*2+j)
top_derr_q  out  NUM_CH*2*ERR_W  last top carries read by LOAD
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  NUM_CH*2*ERR_W  RAM write data, same lane packing
ram_rdata  in  NUM_CH*2*ERR_W  RAM read data, valid 1 cycle after read strobe
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk.
- Reset values: every output 0; FSM in IDLE.
- Arithmetic, per channel c with e0,e1,e2 = derr errors:
  - left0 = e0
  - left1 = (3*e2) >>> 2, computed at ERR_W+2 bits, arithmetic floor shift, truncated to ERR_W
  - top0 = e1 (the channel's own e1)
  - top1 = e2 - left1, truncated to ERR_W
  - No saturation is needed; the result always fits.
- FSM states: IDLE, STORE, LOAD_RD, LOAD_CAP, CLR_L, CLR_T.
- Let C0 be the cycle with start=1 in IDLE. All inputs are captured at the end of C0; busy is high from C1 through the done cycle.
- STORE:
  - C1: ram_en=ram_we=1, ram_addr=x, ram_wdata = packed top carries.
  - left_derr shows the new value from C1.
  - done=1 in C1; then IDLE.
- LOAD:
  - C1: ram_en=1, ram_we=0, ram_addr=x.
  - C2: ram_rdata is valid and is captured.
  - C3: top_derr_q updated; done=1; then IDLE. left_derr unchanged.
- CLR_LEFT: left_derr=0 in C1; done=1 in C1; no RAM access.
- CLR_TOP:
  - Counter n=0..mb_w-1. Cycle C(1+n): ram_en=ram_we=1, ram_addr=n, ram_wdata=0.
  - done in C(mb_w).
  - mb_w=0: no write, done in C1.
- ram_en/ram_we are low in every cycle not listed above.
- start while busy=1 is ignored, including in the done cycle. The next command is accepted the cycle after done. STORE throughput is therefore one command per 2 cycles.
- x wraps naturally within ADDR_W; there is no range check.
- Reset mid-operation:
  - Immediate abort; outputs return to reset values.
  - A partial CLR_TOP leaves RAM only partially cleared; software re-issues it.

Decomposition:
- Package diffusion_err_pkg: op encodings, FSM state enum, lane index helper functions (derr lane, carry lane).
- Sub-module derr_split: combinational, one channel, e0/e1/e2 -> left0/left1/top0/top1. Instantiated NUM_CH times via generate.

Test Plan:
- STORE x=5, ch0 (e0,e1,e2)=(10,-5,7), ch1=(-8,3,-9) -> in C1: ram_we=1, addr=5, wdata=0xFE0302FB; left_derr=0xF9F8050A; done=1 in C1.
- Extremes ch0 e2=-128, ch1 e2=127, other errors 0 -> ch0 left1=0xA0, top1=0xE0; ch1 left1=0x5F, top1=0x20.
- LOAD x=5 after the first test -> read strobe in C1, top_derr_q=0xFE0302FB and done in C3; left_derr unchanged.
- CLR_TOP mb_w=4 -> writes of 0 to addr 0..3 in C1..C4, done in C4. Then LOAD x=3 -> top_derr_q=0. CLR_TOP mb_w=0 -> no write, done in C1.
- Busy rule: STORE, then start=1 again in C1 (done cycle) -> ignored, no second write. start in C2 -> accepted. CLR_LEFT -> left_derr=0, done in C1.
- Reset asserted in C2 of CLR_TOP mb_w=8 -> outputs 0 asynchronously, only addrs 0,1 written, FSM in IDLE, next start accepted.

Source files
------------

// File: rtl/diffusion_err_store_pkg.sv
// Shared types and lane helpers for the chroma error-diffusion store stage.
package diffusion_err_pkg;

    typedef enum logic [1:0] {
        OpStore   = 2'd0,
        OpLoad    = 2'd1,
        OpClrLeft = 2'd2,
        OpClrTop  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StLoadRd,
        StLoadCap,
        StClrL,
        StClrT
    } state_e;

    // Lane of channel c, error k within the packed derr input.
    function automatic int unsigned derr_lane(int unsigned c, int unsigned k);
        return c * 3 + k;
    endfunction

    // Lane of channel c, carry j within the packed left/top carry buses.
    function automatic int unsigned carry_lane(int unsigned c, int unsigned j);
        return c * 2 + j;
    endfunction

endpackage

// File: rtl/diffusion_err_store_if.sv
// Command and row-RAM bus of the error-diffusion store stage.
interface diffusion_err_store_if
    import diffusion_err_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned ADDR_W = 10
);
    logic                       start;
    op_e                        op;
    logic [ADDR_W-1:0]          x;
    logic [ADDR_W-1:0]          mb_w;
    logic [NUM_CH*3*ERR_W-1:0]  derr;
    logic [NUM_CH*2*ERR_W-1:0]  left_derr;
    logic [NUM_CH*2*ERR_W-1:0]  top_derr_q;
    logic                       ram_en;
    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_addr;
    logic [NUM_CH*2*ERR_W-1:0]  ram_wdata;
    logic [NUM_CH*2*ERR_W-1:0]  ram_rdata;
    logic                       busy;
    logic                       done;

    modport slave (
        input  start, op, x, mb_w, derr, ram_rdata,
        output left_derr, top_derr_q, ram_en, ram_we, ram_addr, ram_wdata, busy, done
    );

    modport master (
        output start, op, x, mb_w, derr, ram_rdata,
        input  left_derr, top_derr_q, ram_en, ram_we, ram_addr, ram_wdata, busy, done
    );
endinterface

// File: rtl/diffusion_err_store_derr_split.sv
// Splits one channel's three diffusion errors into left and top carries.
module derr_split #(
    parameter int unsigned ERR_W = 8
) (
    input  logic signed [ERR_W-1:0] i_e0,
    input  logic signed [ERR_W-1:0] i_e1,
    input  logic signed [ERR_W-1:0] i_e2,
    output logic signed [ERR_W-1:0] o_left0,
    output logic signed [ERR_W-1:0] o_left1,
    output logic signed [ERR_W-1:0] o_top0,
    output logic signed [ERR_W-1:0] o_top1
);
    logic signed [ERR_W+1:0] w_e2_ext;
    logic signed [ERR_W+1:0] w_e2_x3;
    logic signed [ERR_W+1:0] w_e2_sh;
    logic        [1:0]       w_unused_hi;

    // 3*e2 needs two extra bits; the floor shift brings it back into ERR_W range.
    assign w_e2_ext = {{2{i_e2[ERR_W-1]}}, i_e2};
    assign w_e2_x3  = w_e2_ext + (w_e2_ext <<< 1);
    assign w_e2_sh  = w_e2_x3 >>> 2;
    assign {w_unused_hi, o_left1} = w_e2_sh;

    assign o_left0 = i_e0;
    assign o_top0  = i_e1;
    assign o_top1  = i_e2 - o_left1;
endmodule

// File: rtl/diffusion_err_store.sv
// Error-diffusion store stage: splits carries, keeps left carries, moves top
// carries to/from the external row RAM and clears it on request.
module diffusion_err_store
    import diffusion_err_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    diffusion_err_store_if.slave  bus
);
    localparam int unsigned CarryW = NUM_CH * 2 * ERR_W;

    logic [CarryW-1:0] w_left;
    logic [CarryW-1:0] w_top;

    state_e            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [CarryW-1:0] r_ram_wdata;
    logic [CarryW-1:0] r_left;
    logic [CarryW-1:0] r_top;
    logic [ADDR_W-1:0] r_mb_w;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        derr_split #(
            .ERR_W (ERR_W)
        ) u_split (
            .i_e0    (bus.derr[derr_lane(c, 0)*ERR_W +: ERR_W]),
            .i_e1    (bus.derr[derr_lane(c, 1)*ERR_W +: ERR_W]),
            .i_e2    (bus.derr[derr_lane(c, 2)*ERR_W +: ERR_W]),
            .o_left0 (w_left[carry_lane(c, 0)*ERR_W +: ERR_W]),
            .o_left1 (w_left[carry_lane(c, 1)*ERR_W +: ERR_W]),
            .o_top0  (w_top[carry_lane(c, 0)*ERR_W +: ERR_W]),
            .o_top1  (w_top[carry_lane(c, 1)*ERR_W +: ERR_W])
        );
    end

    // Command FSM; every output is registered so strobes line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_left      <= '0;
            r_top       <= '0;
            r_mb_w      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        unique case (bus.op)
                            OpStore: begin
                                r_ram_en    <= 1'b1;
                                r_ram_we    <= 1'b1;
                                r_ram_addr  <= bus.x;
                                r_ram_wdata <= w_top;
                                r_left      <= w_left;
                                r_done      <= 1'b1;
                                r_state     <= StStore;
                            end
                            OpLoad: begin
                                r_ram_en   <= 1'b1;
                                r_ram_we   <= 1'b0;
                                r_ram_addr <= bus.x;
                                r_state    <= StLoadRd;
                            end
                            OpClrLeft: begin
                                r_left  <= '0;
                                r_done  <= 1'b1;
                                r_state <= StClrL;
                            end
                            OpClrTop: begin
                                // mb_w of 0 completes at once without touching the RAM.
                                r_mb_w      <= bus.mb_w;
                                r_ram_addr  <= '0;
                                r_ram_wdata <= '0;
                                r_ram_en    <= (bus.mb_w != '0);
                                r_ram_we    <= (bus.mb_w != '0);
                                r_done      <= (bus.mb_w <= ADDR_W'(1));
                                r_state     <= StClrT;
                            end
                        endcase
                    end
                end
                StStore, StClrL, StLoadCap: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                StLoadRd: begin
                    // First cycle drops the strobe; second cycle has valid read data.
                    if (r_ram_en) begin
                        r_ram_en <= 1'b0;
                    end else begin
                        r_top   <= bus.ram_rdata;
                        r_done  <= 1'b1;
                        r_state <= StLoadCap;
                    end
                end
                StClrT: begin
                    if (r_done) begin
                        r_ram_en <= 1'b0;
                        r_ram_we <= 1'b0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= StIdle;
                    end else begin
                        r_ram_addr <= r_ram_addr + ADDR_W'(1);
                        r_done     <= (r_ram_addr + ADDR_W'(2) == r_mb_w);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.ram_en     = r_ram_en;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.left_derr  = r_left;
    assign bus.top_derr_q = r_top;
endmodule

// File: tb/tb_diffusion_err_store.sv
// Directed bench for diffusion_err_store with a behavioural row RAM.
module tb_diffusion_err_store;
    import diffusion_err_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] mem [0:1023];
    logic [9:0]  wr_log [$];

    localparam logic [47:0] Derr1 = 48'hF703F807FB0A;
    localparam logic [47:0] Derr2 = 48'h7F0000800000;

    diffusion_err_store_if #(.NUM_CH(2), .ERR_W(8), .ADDR_W(10)) bus ();

    diffusion_err_store #(
        .NUM_CH (2),
        .ERR_W  (8),
        .ADDR_W (10)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Row RAM: writes commit mid-cycle, reads return one cycle after the strobe.
    always @(negedge clk) begin
        if (bus.ram_en && bus.ram_we) begin
            mem[bus.ram_addr] = bus.ram_wdata;
            wr_log.push_back(bus.ram_addr);
        end
    end

    always @(posedge clk) begin
        if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command in C0 and returns 1 ns into C1.
    task automatic issue(input op_e op, input logic [9:0] x, input logic [9:0] mb_w,
                         input logic [47:0] derr);
        bus.start = 1'b1;
        bus.op    = op;
        bus.x     = x;
        bus.mb_w  = mb_w;
        bus.derr  = derr;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        total++; if ({bus.ram_en, bus.ram_we} !== 2'b00) begin bad++; $display("FAIL rst_ram_en got=%b exp=00", {bus.ram_en, bus.ram_we}); end
        total++; if (bus.ram_addr !== 10'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.ram_addr); end
        total++; if (bus.ram_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.ram_wdata); end
        total++; if (bus.left_derr !== 32'd0) begin bad++; $display("FAIL rst_left got=%h exp=0", bus.left_derr); end
        total++; if (bus.top_derr_q !== 32'd0) begin bad++; $display("FAIL rst_top got=%h exp=0", bus.top_derr_q); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_store();
        wr_log.delete();
        issue(OpStore, 10'd5, 10'd0, Derr1);
        total++; if ({bus.ram_en, bus.ram_we} !== 2'b11) begin bad++; $display("FAIL store_strobe got=%b exp=11", {bus.ram_en, bus.ram_we}); end
        total++; if (bus.ram_addr !== 10'd5) begin bad++; $display("FAIL store_addr got=%h exp=5", bus.ram_addr); end
        total++; if (bus.ram_wdata !== 32'hFE0302FB) begin bad++; $display("FAIL store_wdata got=%h exp=fe0302fb", bus.ram_wdata); end
        total++; if (bus.left_derr !== 32'hF9F8050A) begin bad++; $display("FAIL store_left got=%h exp=f9f8050a", bus.left_derr); end
        total++; if ({bus.done, bus.busy} !== 2'b11) begin bad++; $display("FAIL store_done got=%b exp=11", {bus.done, bus.busy}); end
        step();
        total++; if ({bus.done, bus.busy, bus.ram_en} !== 3'b000) begin bad++; $display("FAIL store_idle got=%b exp=000", {bus.done, bus.busy, bus.ram_en}); end
        total++; if (wr_log.size() !== 1 || mem[5] !== 32'hFE0302FB) begin bad++; $display("FAIL store_ram got=%0d/%h exp=1/fe0302fb", wr_log.size(), mem[5]); end
    endtask

    task automatic test_extremes();
        issue(OpStore, 10'd6, 10'd0, Derr2);
        total++; if (bus.left_derr !== 32'h5F00A000) begin bad++; $display("FAIL ext_left got=%h exp=5f00a000", bus.left_derr); end
        total++; if (bus.ram_wdata !== 32'h2000E000) begin bad++; $display("FAIL ext_top got=%h exp=2000e000", bus.ram_wdata); end
        step();
    endtask

    task automatic test_load();
        issue(OpLoad, 10'd5, 10'd0, 48'd0);
        total++; if ({bus.ram_en, bus.ram_we, bus.done, bus.busy} !== 4'b1001) begin bad++; $display("FAIL load_c1 got=%b exp=1001", {bus.ram_en, bus.ram_we, bus.done, bus.busy}); end
        total++; if (bus.ram_addr !== 10'd5) begin bad++; $display("FAIL load_addr got=%h exp=5", bus.ram_addr); end
        step();
        total++; if ({bus.ram_en, bus.done, bus.busy} !== 3'b001) begin bad++; $display("FAIL load_c2 got=%b exp=001", {bus.ram_en, bus.done, bus.busy}); end
        step();
        total++; if (bus.top_derr_q !== 32'hFE0302FB) begin bad++; $display("FAIL load_top got=%h exp=fe0302fb", bus.top_derr_q); end
        total++; if ({bus.done, bus.busy} !== 2'b11) begin bad++; $display("FAIL load_done got=%b exp=11", {bus.done, bus.busy}); end
        total++; if (bus.left_derr !== 32'h5F00A000) begin bad++; $display("FAIL load_left got=%h exp=5f00a000", bus.left_derr); end
        step();
        total++; if ({bus.done, bus.busy} !== 2'b00) begin bad++; $display("FAIL load_idle got=%b exp=00", {bus.done, bus.busy}); end
    endtask

    task automatic test_clr_top();
        wr_log.delete();
        issue(OpClrTop, 10'd0, 10'd4, 48'd0);
        for (int n = 0; n < 4; n++) begin
            total++;
            if ({bus.ram_en, bus.ram_we} !== 2'b11 || bus.ram_addr !== 10'(n) ||
                bus.ram_wdata !== 32'd0 || bus.done !== (n == 3)) begin
                bad++;
                $display("FAIL clrt_c%0d got=en%b we%b a%0d d%h dn%b exp=en1 we1 a%0d d0 dn%b", n + 1,
                         bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.done, n, n == 3);
            end
            step();
        end
        total++; if ({bus.ram_en, bus.done, bus.busy} !== 3'b000) begin bad++; $display("FAIL clrt_idle got=%b exp=000", {bus.ram_en, bus.done, bus.busy}); end
        total++; if (wr_log.size() !== 4) begin bad++; $display("FAIL clrt_count got=%0d exp=4", wr_log.size()); end
        issue(OpLoad, 10'd3, 10'd0, 48'd0);
        step();
        step();
        total++; if (bus.top_derr_q !== 32'd0 || bus.done !== 1'b1) begin bad++; $display("FAIL clrt_load got=%h/%b exp=0/1", bus.top_derr_q, bus.done); end
        step();
        wr_log.delete();
        issue(OpClrTop, 10'd0, 10'd0, 48'd0);
        total++; if ({bus.ram_en, bus.done, bus.busy} !== 3'b011) begin bad++; $display("FAIL clrt0_c1 got=%b exp=011", {bus.ram_en, bus.done, bus.busy}); end
        step();
        total++; if (wr_log.size() !== 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL clrt0_end got=%0d/%b exp=0/0", wr_log.size(), bus.busy); end
    endtask

    task automatic test_back_to_back();
        wr_log.delete();
        issue(OpStore, 10'd7, 10'd0, Derr1);
        // Start held through the done cycle: ignored there, accepted in C2.
        bus.start = 1'b1;
        bus.x     = 10'd9;
        step();
        total++; if ({bus.ram_en, bus.done, bus.busy} !== 3'b000) begin bad++; $display("FAIL b2b_c2 got=%b exp=000", {bus.ram_en, bus.done, bus.busy}); end
        bus.x = 10'd8;
        step();
        bus.start = 1'b0;
        total++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 10'd8 || bus.done !== 1'b1) begin bad++; $display("FAIL b2b_second got=en%b a%0d dn%b exp=en1 a8 dn1", bus.ram_en, bus.ram_addr, bus.done); end
        step();
        total++; if (wr_log.size() !== 2 || wr_log[0] !== 10'd7 || wr_log[1] !== 10'd8) begin bad++; $display("FAIL b2b_log got=%0d writes exp=2 (7,8)", wr_log.size()); end
        issue(OpClrLeft, 10'd0, 10'd0, 48'd0);
        total++; if (bus.left_derr !== 32'd0 || bus.done !== 1'b1 || bus.ram_en !== 1'b0) begin bad++; $display("FAIL clrl got=%h/%b/%b exp=0/1/0", bus.left_derr, bus.done, bus.ram_en); end
        step();
    endtask

    task automatic test_reset_mid();
        wr_log.delete();
        issue(OpClrTop, 10'd0, 10'd8, 48'd0);
        step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if ({bus.busy, bus.done, bus.ram_en, bus.ram_we} !== 4'b0000 || bus.ram_addr !== 10'd0) begin bad++; $display("FAIL rmid_out got=%b a%0d exp=0000 a0", {bus.busy, bus.done, bus.ram_en, bus.ram_we}, bus.ram_addr); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (wr_log.size() !== 2 || wr_log[0] !== 10'd0 || wr_log[1] !== 10'd1) begin bad++; $display("FAIL rmid_log got=%0d writes exp=2 (0,1)", wr_log.size()); end
        issue(OpStore, 10'd2, 10'd0, Derr1);
        total++; if (bus.done !== 1'b1 || bus.ram_addr !== 10'd2 || bus.ram_wdata !== 32'hFE0302FB) begin bad++; $display("FAIL rmid_next got=dn%b a%0d d%h exp=dn1 a2 dfe0302fb", bus.done, bus.ram_addr, bus.ram_wdata); end
        step();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        bus.start     = 1'b0;
        bus.op        = OpStore;
        bus.x         = '0;
        bus.mb_w      = '0;
        bus.derr      = '0;
        bus.ram_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEADBEEF;
        test_reset();
        test_store();
        test_extremes();
        test_load();
        test_clr_top();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
